// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, ALU
// codes, state encoding, the control-word struct and an opcode classifier.
package cpu_ctrl_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU operation codes
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_INC  = 5'b11111;

  // Control-step states; T0..T7 are numbered by step so a state value is
  // also the step index within the current instruction.
  localparam logic [3:0] ST_T0   = 4'd0;
  localparam logic [3:0] ST_T1   = 4'd1;
  localparam logic [3:0] ST_T2   = 4'd2;
  localparam logic [3:0] ST_T3   = 4'd3;
  localparam logic [3:0] ST_T4   = 4'd4;
  localparam logic [3:0] ST_T5   = 4'd5;
  localparam logic [3:0] ST_T6   = 4'd6;
  localparam logic [3:0] ST_T7   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  // Instruction classes: opcodes sharing one execute sequence
  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_ADDI, K_LDI, K_LD, K_ST,
    K_JAL, K_JR, K_BR, K_IN, K_OUT, K_HALT
  } kind_t;

  // One complete DataPath control word
  typedef struct packed {
    logic       hi_in;
    logic       lo_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       mar_in;
    logic       y_in;
    logic       oport_in;
    logic       ir_in;
    logic       hi_out;
    logic       lo_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       mdr_out;
    logic       iport_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       con_in;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_code;
  } ctrl_t;

  // Undefined opcodes fall into K_NOP so they execute as a nop.
  function automatic kind_t kind_of(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: kind_of = K_ALU;
      OP_ADDI:                       kind_of = K_ADDI;
      OP_LDI:                        kind_of = K_LDI;
      OP_LD:                         kind_of = K_LD;
      OP_ST:                         kind_of = K_ST;
      OP_JAL:                        kind_of = K_JAL;
      OP_JR:                         kind_of = K_JR;
      OP_BR:                         kind_of = K_BR;
      OP_IN:                         kind_of = K_IN;
      OP_OUT:                        kind_of = K_OUT;
      OP_HALT:                       kind_of = K_HALT;
      default:                       kind_of = K_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decoder: maps (state, opcode) to the DataPath control word.
// ConOut only steers the conditional PC load in the branch write-back step.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [4:0] opcode,
  input  logic       con_out,
  output ctrl_t      ctrl
);

  kind_t kind;
  assign kind = kind_of(opcode);

  // Decode the control word for the current step; anything not named is 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_T0: begin
        ctrl.pc_out   = 1'b1;
        ctrl.mar_in   = 1'b1;
        ctrl.z_in     = 1'b1;
        ctrl.alu_code = ALU_INC;
      end
      ST_T1: begin
        ctrl.zlo_out  = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_T3: begin
        case (kind)
          K_ALU, K_ADDI: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          K_LDI, K_LD, K_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          K_JAL: begin
            ctrl.grb    = 1'b1;
            ctrl.r_in   = 1'b1;
            ctrl.pc_out = 1'b1;
          end
          K_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
          K_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          K_IN: begin
            ctrl.iport_out = 1'b1;
            ctrl.gra       = 1'b1;
            ctrl.r_in      = 1'b1;
          end
          K_OUT: begin
            ctrl.gra      = 1'b1;
            ctrl.r_out    = 1'b1;
            ctrl.oport_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (kind)
          K_ALU: begin
            ctrl.grc      = 1'b1;
            ctrl.r_out    = 1'b1;
            ctrl.z_in     = 1'b1;
            ctrl.alu_code = opcode;
          end
          K_ADDI, K_LDI, K_LD, K_ST: begin
            ctrl.c_out    = 1'b1;
            ctrl.z_in     = 1'b1;
            ctrl.alu_code = ALU_ADD;
          end
          K_JAL: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
          K_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (kind)
          K_ALU, K_ADDI, K_LDI: begin
            ctrl.zlo_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          K_LD, K_ST: begin
            ctrl.zlo_out = 1'b1;
            ctrl.mar_in  = 1'b1;
          end
          K_BR: begin
            ctrl.c_out    = 1'b1;
            ctrl.z_in     = 1'b1;
            ctrl.alu_code = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (kind)
          K_LD: begin
            ctrl.mem_read = 1'b1;
            ctrl.mdr_in   = 1'b1;
          end
          K_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          K_BR: begin
            ctrl.zlo_out = 1'b1;
            ctrl.pc_in   = con_out;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (kind)
          K_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          K_ST: ctrl.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: step-state register and next-state sequencing.
// Control outputs come from ctrl_decode and are forced to 0 while clear is
// high, so a clear aborts even a memwrite already being presented.
// state is a debug view of the step register.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        ConOut,
  output logic        HiIn,
  output logic        LoIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        MARIn,
  output logic        YIn,
  output logic        OPortIn,
  output logic        IRIn,
  output logic        HiOut,
  output logic        LoOut,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        PCOut,
  output logic        MDROut,
  output logic        IPortOut,
  output logic        COut,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        ROut,
  output logic        BAOut,
  output logic        Conin,
  output logic        memread,
  output logic        memwrite,
  output logic [4:0]  ALUCode,
  output logic        run,
  output logic [3:0]  state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [4:0] opcode;
  kind_t      kind;
  ctrl_t      dec;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign kind      = kind_of(opcode);
  assign unused_ir = ^IR[26:0];

  ctrl_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .con_out (ConOut),
    .ctrl    (dec)
  );

  // Step register; clear returns to the fetch step from any state
  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  // Next step: fetch is common, then each class leaves for T0 at its last step
  always_comb begin
    state_d = ST_T0;
    case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        case (kind)
          K_HALT:                   state_d = ST_HALT;
          K_NOP, K_IN, K_OUT, K_JR: state_d = ST_T0;
          default:                  state_d = ST_T4;
        endcase
      end
      ST_T4:   state_d = (kind == K_JAL) ? ST_T0 : ST_T5;
      ST_T5: begin
        if (kind == K_ALU || kind == K_ADDI || kind == K_LDI) state_d = ST_T0;
        else                                                  state_d = ST_T6;
      end
      ST_T6:   state_d = (kind == K_BR) ? ST_T0 : ST_T7;
      ST_T7:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  // Suppress every control during the clear cycle
  always_comb begin
    ctrl = dec;
    if (clear) ctrl = '0;
  end

  assign HiIn     = ctrl.hi_in;
  assign LoIn     = ctrl.lo_in;
  assign ZIn      = ctrl.z_in;
  assign PCIn     = ctrl.pc_in;
  assign MDRIn    = ctrl.mdr_in;
  assign MARIn    = ctrl.mar_in;
  assign YIn      = ctrl.y_in;
  assign OPortIn  = ctrl.oport_in;
  assign IRIn     = ctrl.ir_in;
  assign HiOut    = ctrl.hi_out;
  assign LoOut    = ctrl.lo_out;
  assign ZHiOut   = ctrl.zhi_out;
  assign ZLoOut   = ctrl.zlo_out;
  assign PCOut    = ctrl.pc_out;
  assign MDROut   = ctrl.mdr_out;
  assign IPortOut = ctrl.iport_out;
  assign COut     = ctrl.c_out;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign RIn      = ctrl.r_in;
  assign ROut     = ctrl.r_out;
  assign BAOut    = ctrl.ba_out;
  assign Conin    = ctrl.con_in;
  assign memread  = ctrl.mem_read;
  assign memwrite = ctrl.mem_write;
  assign ALUCode  = ctrl.alu_code;

  assign run   = (state_q != ST_HALT);
  assign state = state_q;

endmodule
